// File: rtl/scarv_cop_pmul_ctrl.sv
// Multi-cycle packed multiply sequencer for the COP packed-arithmetic path.
// Every lane runs its own shift-add loop in parallel; results come back on one idone writeback.
module scarv_cop_pmul_ctrl #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        pmul_ivalid,
    output logic        pmul_idone,
    input  logic        pmul_flush,
    input  logic [31:0] pmul_rs1,
    input  logic [31:0] pmul_rs2,
    input  logic [2:0]  pmul_pw,
    input  logic        pmul_hi,
    output logic        pmul_busy,
    output logic [3:0]  pmul_cpr_rd_ben,
    output logic [31:0] pmul_cpr_rd_wdata
);

    localparam int BPC_LOG2 = (BITS_PER_CYCLE == 2) ? 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;
    state_t state_q, state_d;

    logic [31:0] mcand_q, mplier_q;
    logic [2:0]  pw_q;
    logic        hi_q;
    logic [63:0] acc_q, acc_next;
    logic [4:0]  cnt_q, cnt_init;
    logic [5:0]  pos_q, lane_w;
    logic [31:0] res_sel;
    logic [63:0] acc_step [5];
    logic [31:0] res_mode [5];

    assign lane_w   = 6'd32 >> pmul_pw;
    assign cnt_init = 5'((lane_w >> BPC_LOG2) - 6'd1);

    always_ff @(posedge g_clk) begin
        if (!g_resetn) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // flush outranks everything; dropping ivalid mid-run abandons the operation
    always_comb begin
        // NOTE: assign a default first so no path leaves state_d unassigned, which would infer a latch.
        state_d = state_q;
        if (pmul_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (pmul_ivalid) state_d = (pmul_pw <= 3'd4) ? S_RUN : S_ERR;
                S_RUN:   if (!pmul_ivalid) state_d = S_IDLE;
                         else if (cnt_q == 5'd0) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        // NOTE: the datapath registers are reset too, so an aborted operation leaves nothing stale behind.
        if (!g_resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            pw_q     <= '0;
            hi_q     <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
        end else if (state_q == S_IDLE && state_d == S_RUN) begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            mcand_q  <= pmul_rs1;
            mplier_q <= pmul_rs2;
            pw_q     <= pmul_pw;
            hi_q     <= pmul_hi;
            acc_q    <= '0;
            cnt_q    <= cnt_init;
            pos_q    <= '0;
        end else if (state_q == S_RUN) begin
            acc_q    <= acc_next;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            cnt_q    <= cnt_q - 5'd1;
            pos_q    <= pos_q + 6'(BITS_PER_CYCLE);
        end
    end

    // One lane datapath per pack width; the multiplier register shifts as a whole,
    // and a lane never consumes more than w bits, so neighbour bits never leak in.
    for (genvar m = 0; m < 5; m++) begin : g_mode
        localparam int W     = 32 >> m;
        localparam int LANES = 32 / W;
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [2*W-1:0] a_ext, sum;
            logic [2*W-1:0] term [BITS_PER_CYCLE];
            assign a_ext = {{W{1'b0}}, mcand_q[W*j +: W]};
            for (genvar b = 0; b < BITS_PER_CYCLE; b++) begin : g_bit
                assign term[b] = mplier_q[W*j+b] ? (a_ext << (pos_q + 6'(b))) : '0;
            end
            always_comb begin
                sum = acc_q[2*W*j +: 2*W];
                for (int b = 0; b < BITS_PER_CYCLE; b++) sum = sum + term[b];
            end
            assign acc_step[m][2*W*j +: 2*W] = sum;
            assign res_mode[m][W*j +: W]     = hi_q ? acc_q[2*W*j+W +: W] : acc_q[2*W*j +: W];
        end
    end

    always_comb begin
        acc_next = acc_q;
        res_sel  = '0;
        for (int m = 0; m < 5; m++) begin
            if (pw_q == 3'(m)) begin
                acc_next = acc_step[m];
                res_sel  = res_mode[m];
            end
        end
    end

    always_comb begin
        pmul_idone        = 1'b0;
        pmul_busy         = 1'b0;
        pmul_cpr_rd_ben   = 4'b0000;
        pmul_cpr_rd_wdata = '0;
        case (state_q)
            S_RUN:  pmul_busy = 1'b1;
            S_DONE: begin
                pmul_idone        = 1'b1;
                pmul_busy         = 1'b1;
                pmul_cpr_rd_ben   = 4'b1111;
                pmul_cpr_rd_wdata = res_sel;
            end
            S_ERR:  pmul_idone = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scarv_cop_pmul_ctrl.sv
// Bench for scarv_cop_pmul_ctrl: BPC=1 and BPC=2 instances checked every cycle
// against a transaction-level model built from per-lane integer products.
module tb_scarv_cop_pmul_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ivalid [2];
    logic        flush  [2];
    logic [31:0] rs1    [2];
    logic [31:0] rs2    [2];
    logic [2:0]  pwv    [2];
    logic        hiv    [2];
    logic        idone  [2];
    logic        busy   [2];
    logic [3:0]  ben    [2];
    logic [31:0] wdata  [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    scarv_cop_pmul_ctrl #(.BITS_PER_CYCLE(1)) dut1 (
        .g_clk(clk), .g_resetn(rstn), .pmul_ivalid(ivalid[0]), .pmul_idone(idone[0]),
        .pmul_flush(flush[0]), .pmul_rs1(rs1[0]), .pmul_rs2(rs2[0]), .pmul_pw(pwv[0]),
        .pmul_hi(hiv[0]), .pmul_busy(busy[0]), .pmul_cpr_rd_ben(ben[0]),
        .pmul_cpr_rd_wdata(wdata[0])
    );

    scarv_cop_pmul_ctrl #(.BITS_PER_CYCLE(2)) dut2 (
        .g_clk(clk), .g_resetn(rstn), .pmul_ivalid(ivalid[1]), .pmul_idone(idone[1]),
        .pmul_flush(flush[1]), .pmul_rs1(rs1[1]), .pmul_rs2(rs2[1]), .pmul_pw(pwv[1]),
        .pmul_hi(hiv[1]), .pmul_busy(busy[1]), .pmul_cpr_rd_ben(ben[1]),
        .pmul_cpr_rd_wdata(wdata[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference result: full integer product per lane, then pick the low or high half.
    function automatic logic [31:0] pmul_ref(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] pw, input logic hi);
        int w;
        longint unsigned mask, x, y, p, lane;
        logic [31:0] r;
        w    = 32 >> pw;
        mask = (64'd1 << w) - 64'd1;
        r    = '0;
        for (int j = 0; j < 32 / w; j++) begin
            x    = ({32'd0, a} >> (w * j)) & mask;
            y    = ({32'd0, b} >> (w * j)) & mask;
            p    = x * y;
            lane = hi ? ((p >> w) & mask) : (p & mask);
            r    = r | (32'(lane) << (w * j));
        end
        return r;
    endfunction

    function automatic int op_latency(input int k, input logic [2:0] pw);
        return (pw <= 3'd4) ? 1 + (32 >> pw) / (k + 1) : 1;
    endfunction

    // Model: one pending transaction per instance, tracked by absolute cycle numbers.
    int          cyc = 0;
    bit          m_act   [2];
    bit          m_legal [2];
    int          m_done  [2];
    logic [31:0] m_res   [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn || flush[k]) begin
                m_act[k] <= 1'b0;
            end else if (m_act[k]) begin
                if (cyc == m_done[k] || !ivalid[k]) m_act[k] <= 1'b0;
            end else if (ivalid[k]) begin
                m_act[k]   <= 1'b1;
                m_legal[k] <= (pwv[k] <= 3'd4);
                m_done[k]  <= cyc + op_latency(k, pwv[k]);
                m_res[k]   <= (pwv[k] <= 3'd4) ? pmul_ref(rs1[k], rs2[k], pwv[k], hiv[k]) : 32'h0;
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cyc_idone%0d", k), 32'(idone[k]),
                      32'(m_act[k] && cyc == m_done[k]));
                check($sformatf("cyc_busy%0d", k), 32'(busy[k]), 32'(m_act[k] && m_legal[k]));
                check($sformatf("cyc_ben%0d", k), 32'(ben[k]),
                      (m_act[k] && m_legal[k] && cyc == m_done[k]) ? 32'hF : 32'h0);
                check($sformatf("cyc_wdata%0d", k), wdata[k],
                      (m_act[k] && m_legal[k] && cyc == m_done[k]) ? m_res[k] : 32'h0);
            end
        end
    end

    // Issue one op; operands are scrambled during RUN to show they are not resampled.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] pw, input logic hi, input bit hold,
                          output int lat, output logic [31:0] wd, output logic [3:0] be);
        @(posedge clk); #2;
        ivalid[k] = 1'b1; rs1[k] = a; rs2[k] = b; pwv[k] = pw; hiv[k] = hi;
        lat = -1; wd = '0; be = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (idone[k]) begin
                lat = n; wd = wdata[k]; be = ben[k];
                break;
            end
            if (n > 0) begin
                rs1[k] = $urandom; rs2[k] = $urandom;
                pwv[k] = 3'($urandom); hiv[k] = 1'($urandom);
            end
        end
        if (lat < 0) check($sformatf("idone_timeout%0d", k), 32'h0, 32'h1);
        if (!hold) begin
            @(posedge clk); #2;
            ivalid[k] = 1'b0;
        end
    endtask

    task automatic run_expect(input int k, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] pw, input logic hi, input bit hold,
                              input string name, input int exp_lat, input logic [31:0] exp_wd,
                              input logic [3:0] exp_be);
        int lat;
        logic [31:0] wd;
        logic [3:0]  be;
        run_op(k, a, b, pw, hi, hold, lat, wd, be);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_wdata"}, wd, exp_wd);
        check({name, "_ben"}, 32'(be), 32'(exp_be));
    endtask

    // mode 0 = flush pulse, 1 = ivalid drop, 2 = reset pulse; applied in RUN cycle `at`.
    task automatic abort_op(input int k, input int mode, input int at, input logic [2:0] pw);
        @(posedge clk); #2;
        ivalid[k] = 1'b1; rs1[k] = $urandom; rs2[k] = $urandom; pwv[k] = pw; hiv[k] = 1'($urandom);
        repeat (at) @(posedge clk);
        #2;
        ivalid[k] = 1'b0;
        if (mode == 0) flush[k] = 1'b1;
        if (mode == 2) rstn = 1'b0;
        @(posedge clk); #2;
        flush[k] = 1'b0;
        rstn     = 1'b1;
        @(negedge clk);
        check($sformatf("abort%0d_busy", mode), 32'(busy[k]), 32'h0);
        check($sformatf("abort%0d_idone", mode), 32'(idone[k]), 32'h0);
        if (mode == 2) begin
            check("rst_ben", 32'(ben[k]), 32'h0);
            check("rst_wdata", wdata[k], 32'h0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ivalid[k] = 1'b0; flush[k] = 1'b0; rs1[k] = '0; rs2[k] = '0; pwv[k] = '0; hiv[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2 chk_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_idone", 32'(idone[k]), 32'h0);
            check("reset_busy", 32'(busy[k]), 32'h0);
            check("reset_ben", 32'(ben[k]), 32'h0);
            check("reset_wdata", wdata[k], 32'h0);
        end
        @(posedge clk); #2 rstn = 1'b1;

        check("ref_t1_lo", pmul_ref(32'h0001_0000, 32'h0001_0000, 3'd0, 1'b0), 32'h0000_0000);
        check("ref_t1_hi", pmul_ref(32'h0001_0000, 32'h0001_0000, 3'd0, 1'b1), 32'h0000_0001);
        check("ref_t2_lo", pmul_ref(32'hFFFF_0003, 32'hFFFF_0005, 3'd1, 1'b0), 32'h0001_000F);
        check("ref_t2_hi", pmul_ref(32'hFFFF_0003, 32'hFFFF_0005, 3'd1, 1'b1), 32'hFFFE_0000);
        check("ref_t3_lo", pmul_ref(32'h1020_FF02, 32'h1008_FF03, 3'd2, 1'b0), 32'h0000_0106);
        check("ref_t3_hi", pmul_ref(32'h1020_FF02, 32'h1008_FF03, 3'd2, 1'b1), 32'h0101_FE00);
        check("ref_t4_lo", pmul_ref(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b0), 32'h5555_5555);
        check("ref_t4_hi", pmul_ref(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b1), 32'hAAAA_AAAA);

        run_expect(0, 32'h0001_0000, 32'h0001_0000, 3'd0, 1'b0, 1'b0, "t1_lo", 33, 32'h0000_0000, 4'hF);
        run_expect(0, 32'h0001_0000, 32'h0001_0000, 3'd0, 1'b1, 1'b0, "t1_hi", 33, 32'h0000_0001, 4'hF);
        run_expect(0, 32'hFFFF_0003, 32'hFFFF_0005, 3'd1, 1'b0, 1'b0, "t2_lo", 17, 32'h0001_000F, 4'hF);
        run_expect(0, 32'hFFFF_0003, 32'hFFFF_0005, 3'd1, 1'b1, 1'b0, "t2_hi", 17, 32'hFFFE_0000, 4'hF);
        run_expect(0, 32'h1020_FF02, 32'h1008_FF03, 3'd2, 1'b0, 1'b0, "t3_lo", 9, 32'h0000_0106, 4'hF);
        run_expect(0, 32'h1020_FF02, 32'h1008_FF03, 3'd2, 1'b1, 1'b0, "t3_hi", 9, 32'h0101_FE00, 4'hF);
        run_expect(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b0, "t4_lo", 3, 32'h5555_5555, 4'hF);
        run_expect(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b1, 1'b0, "t4_hi", 3, 32'hAAAA_AAAA, 4'hF);
        run_expect(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b0, 1'b0, "t4b_lo", 2, 32'h5555_5555, 4'hF);
        run_expect(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b1, 1'b0, "t4b_hi", 2, 32'hAAAA_AAAA, 4'hF);
        run_expect(1, 32'hFFFF_0003, 32'hFFFF_0005, 3'd1, 1'b1, 1'b0, "t2b_hi", 9, 32'hFFFE_0000, 4'hF);

        abort_op(0, 0, 5, 3'd0);
        run_expect(0, 32'hFFFF_0003, 32'hFFFF_0005, 3'd1, 1'b0, 1'b0, "t5_after", 17, 32'h0001_000F, 4'hF);
        abort_op(0, 1, 5, 3'd0);
        abort_op(0, 2, 5, 3'd0);

        run_expect(0, 32'h1234_5678, 32'h9ABC_DEF0, 3'd6, 1'b0, 1'b1, "t6_err", 1, 32'h0, 4'h0);
        run_expect(0, 32'h1020_FF02, 32'h1008_FF03, 3'd2, 1'b1, 1'b0, "t6_next", 9, 32'h0101_FE00, 4'hF);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] a, b;
                logic [2:0]  pw;
                logic        hi;
                bit          legal;
                a  = $urandom; b = $urandom; hi = 1'($urandom);
                pw = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
                legal = (pw <= 3'd4);
                if (legal && $urandom_range(0, 7) == 0 && op_latency(k, pw) > 2) begin
                    abort_op(k, int'($urandom_range(0, 2)), int'($urandom_range(1, op_latency(k, pw) - 2)), pw);
                end else begin
                    run_expect(k, a, b, pw, hi, 1'($urandom), "rand", op_latency(k, pw),
                               legal ? pmul_ref(a, b, pw, hi) : 32'h0, legal ? 4'hF : 4'h0);
                end
            end
            @(posedge clk); #2 ivalid[k] = 1'b0;
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
